// File: rtl/bsr_meta_walker.sv
// Walks BSR row_ptr/col-index metadata in the metadata cache and emits one job
// per non-zero block over a valid/ready handshake.
module bsr_meta_walker #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ROWPTR_BASE = 8'h00,
  parameter logic [ADDR_W-1:0] COLIDX_BASE = 8'h40,
  parameter int                MAX_ROWS    = 63,
  parameter int                MAX_NNZ     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       cfg_num_block_rows,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] meta_raddr,
  output logic              meta_ren,
  input  logic [31:0]       meta_rdata,
  input  logic              meta_rvalid,
  output logic              job_valid,
  input  logic              job_ready,
  output logic [15:0]       job_block_row,
  output logic [15:0]       job_block_col,
  output logic [15:0]       job_block_idx,
  output logic              job_last
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_PTR   = 3'd1,
    WAIT_PTR = 3'd2,
    RD_COL   = 3'd3,
    WAIT_COL = 3'd4,
    EMIT     = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t            state_r;
  logic [15:0]       r_r, n_r, k_r, ptr_lo_r, ptr_hi_r;
  logic              need_first_r, col_vld_r;
  logic [7:0]        col_w_r;
  logic [31:0]       col_word_r;
  logic              busy_r, done_r, err_r, meta_ren_r, job_valid_r, job_last_r;
  logic [1:0]        err_code_r;
  logic [ADDR_W-1:0] meta_raddr_r;
  logic [15:0]       job_row_r, job_col_r, job_idx_r;

  logic [15:0]       step_k_s, step_hi_s, ptr_off_s;
  logic              step_more_s, step_hit_s, step_last_s, ptr_bad_s, do_step_s, row_last_s;
  logic [ADDR_W-1:0] ptr_addr_s, col_addr_s;

  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic odd);
    if (odd) begin
      return word[31:16];
    end else begin
      return word[15:0];
    end
  endfunction

  // Row-step operands: fresh pointers from the cache, or the next k of the current row
  always_comb begin
    step_k_s  = k_r + 16'd1;
    step_hi_s = ptr_hi_r;
    if (state_r == WAIT_PTR) begin
      step_k_s  = ptr_lo_r;
      step_hi_s = meta_rdata[15:0];
    end else begin
      step_k_s  = k_r + 16'd1;
      step_hi_s = ptr_hi_r;
    end
  end

  assign row_last_s  = (r_r == n_r - 16'd1);
  assign step_more_s = (step_k_s < step_hi_s);
  assign step_hit_s  = col_vld_r && (col_w_r == step_k_s[8:1]);
  assign step_last_s = row_last_s && (step_k_s == step_hi_s - 16'd1);
  assign ptr_bad_s   = (meta_rdata[15:0] < ptr_lo_r) || (meta_rdata[15:0] > 16'(MAX_NNZ));
  assign do_step_s   = ((state_r == WAIT_PTR) && meta_rvalid && !need_first_r && !ptr_bad_s) ||
                       ((state_r == EMIT) && job_ready);
  assign ptr_off_s   = need_first_r ? r_r : r_r + 16'd1;
  assign ptr_addr_s  = ROWPTR_BASE + ptr_off_s[ADDR_W-1:0];
  assign col_addr_s  = COLIDX_BASE + ADDR_W'(k_r[8:1]);

  // Walker FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      r_r          <= 16'd0;
      n_r          <= 16'd0;
      k_r          <= 16'd0;
      ptr_lo_r     <= 16'd0;
      ptr_hi_r     <= 16'd0;
      need_first_r <= 1'b0;
      col_vld_r    <= 1'b0;
      col_w_r      <= 8'd0;
      col_word_r   <= 32'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= 2'd0;
      meta_ren_r   <= 1'b0;
      meta_raddr_r <= '0;
      job_valid_r  <= 1'b0;
      job_row_r    <= 16'd0;
      job_col_r    <= 16'd0;
      job_idx_r    <= 16'd0;
      job_last_r   <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      meta_ren_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
            r_r          <= 16'd0;
            n_r          <= cfg_num_block_rows;
            need_first_r <= 1'b1;
            col_vld_r    <= 1'b0;
            busy_r       <= 1'b1;
            if (cfg_num_block_rows == 16'd0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else if (cfg_num_block_rows > 16'(MAX_ROWS)) begin
              err_r      <= 1'b1;
              err_code_r <= 2'd1;
              state_r    <= DONE;
              done_r     <= 1'b1;
            end else begin
              state_r <= RD_PTR;
            end
          end
        end
        RD_PTR: begin
          meta_ren_r   <= 1'b1;
          meta_raddr_r <= ptr_addr_s;
          state_r      <= WAIT_PTR;
        end
        WAIT_PTR: begin
          if (meta_rvalid) begin
            if (need_first_r) begin
              ptr_lo_r     <= meta_rdata[15:0];
              need_first_r <= 1'b0;
              state_r      <= RD_PTR;
            end else if (meta_rdata[15:0] < ptr_lo_r) begin
              err_r      <= 1'b1;
              err_code_r <= 2'd2;
              state_r    <= DONE;
              done_r     <= 1'b1;
            end else if (ptr_bad_s) begin
              err_r      <= 1'b1;
              err_code_r <= 2'd3;
              state_r    <= DONE;
              done_r     <= 1'b1;
            end else begin
              ptr_hi_r <= meta_rdata[15:0];
            end
          end
        end
        RD_COL: begin
          meta_ren_r   <= 1'b1;
          meta_raddr_r <= col_addr_s;
          state_r      <= WAIT_COL;
        end
        WAIT_COL: begin
          if (meta_rvalid) begin
            col_word_r  <= meta_rdata;
            col_w_r     <= k_r[8:1];
            col_vld_r   <= 1'b1;
            job_valid_r <= 1'b1;
            job_row_r   <= r_r;
            job_col_r   <= pick_half(meta_rdata, k_r[0]);
            job_idx_r   <= k_r;
            job_last_r  <= row_last_s && (k_r == ptr_hi_r - 16'd1);
            state_r     <= EMIT;
          end
        end
        EMIT: begin
          if (job_ready) begin
            job_valid_r <= 1'b0;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase

      // Row step: emit from the cached word, fetch a new word, or advance the row
      if (do_step_s) begin
        k_r <= step_k_s;
        if (step_more_s) begin
          if (step_hit_s) begin
            job_valid_r <= 1'b1;
            job_row_r   <= r_r;
            job_col_r   <= pick_half(col_word_r, step_k_s[0]);
            job_idx_r   <= step_k_s;
            job_last_r  <= step_last_s;
            state_r     <= EMIT;
          end else begin
            state_r <= RD_COL;
          end
        end else begin
          ptr_lo_r <= step_hi_s;
          r_r      <= r_r + 16'd1;
          if (r_r + 16'd1 == n_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= RD_PTR;
          end
        end
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign err_code      = err_code_r;
  assign meta_ren      = meta_ren_r;
  assign meta_raddr    = meta_raddr_r;
  assign job_valid     = job_valid_r;
  assign job_block_row = job_row_r;
  assign job_block_col = job_col_r;
  assign job_block_idx = job_idx_r;
  assign job_last      = job_last_r;

endmodule

// File: tb/tb_bsr_meta_walker.sv
// Bench for bsr_meta_walker: cache responder plus a loop-based reference walk
// over the same cache image, directed scenarios and randomized walks.
module tb_bsr_meta_walker;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, err, meta_ren, meta_rvalid;
  logic        job_valid, job_ready, job_last;
  logic [15:0] cfg_num_block_rows, job_block_row, job_block_col, job_block_idx;
  logic [1:0]  err_code;
  logic [7:0]  meta_raddr;
  logic [31:0] meta_rdata;

  always #5 clk = ~clk;

  bsr_meta_walker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_block_rows(cfg_num_block_rows),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .meta_raddr(meta_raddr), .meta_ren(meta_ren), .meta_rdata(meta_rdata),
    .meta_rvalid(meta_rvalid), .job_valid(job_valid), .job_ready(job_ready),
    .job_block_row(job_block_row), .job_block_col(job_block_col),
    .job_block_idx(job_block_idx), .job_last(job_last)
  );

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] idx;
    logic        last;
  } job_t;

  logic [31:0] mem [256];
  job_t        exp_q[$];
  job_t        obs_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_reads, reads, rd40, done_cnt, busy_cnt, lat, cnt;
  logic        exp_err;
  logic [1:0]  exp_code;
  logic        pend, hold_chk, ready_rand, addr_chk;
  logic [7:0]  paddr;
  job_t        hold_job;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic job_t cur_job();
    return {job_block_row, job_block_col, job_block_idx, job_last};
  endfunction

  function automatic logic [63:0] out_vec();
    return {busy, done, err, err_code, meta_ren, meta_raddr, job_valid,
            job_block_row, job_block_col, job_block_idx, job_last};
  endfunction

  // One clock: handshake monitor, stall checks, cache responder, ready driver
  task automatic cycle();
    if (job_valid && job_ready) obs_q.push_back(cur_job());
    hold_chk = job_valid && !job_ready && rst_n;
    hold_job = cur_job();
    @(negedge clk);
    if (hold_chk) begin
      check("hold_valid", 64'(job_valid), 64'd1);
      check("hold_fields", 64'(cur_job()), 64'(hold_job));
      check("hold_no_read", 64'(meta_ren), 64'd0);
    end
    meta_rvalid = 1'b0;
    if (pend) begin
      if (addr_chk && rst_n) check("raddr_stable", 64'(meta_raddr), 64'(paddr));
      cnt--;
      if (cnt == 0) begin
        meta_rvalid = 1'b1;
        meta_rdata  = mem[paddr];
        pend        = 1'b0;
      end
    end
    if (meta_ren) begin
      check("one_outstanding", 64'(pend), 64'd0);
      pend  = 1'b1;
      cnt   = lat;
      paddr = meta_raddr;
      reads++;
      if (meta_raddr == 8'h40) rd40++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (ready_rand) job_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference walk computed directly from the cache image
  task automatic ref_walk(input int n);
    int lo, hi, cw;
    bit cv;
    logic [31:0] wd;
    job_t j;
    exp_q.delete();
    exp_reads = 0;
    exp_err   = 1'b0;
    exp_code  = 2'd0;
    if (n == 0) return;
    if (n > 63) begin
      exp_err  = 1'b1;
      exp_code = 2'd1;
      return;
    end
    lo = int'(mem[0][15:0]);
    exp_reads = 1;
    cv = 1'b0;
    cw = 0;
    for (int r = 0; r < n; r++) begin
      hi = int'(mem[r + 1][15:0]);
      exp_reads++;
      if (hi < lo) begin
        exp_err  = 1'b1;
        exp_code = 2'd2;
        return;
      end
      if (hi > 256) begin
        exp_err  = 1'b1;
        exp_code = 2'd3;
        return;
      end
      for (int k = lo; k < hi; k++) begin
        if (!cv || cw != k / 2) begin
          exp_reads++;
          cv = 1'b1;
          cw = k / 2;
        end
        wd = mem[64 + k / 2];
        j.row  = 16'(r);
        j.col  = (k % 2 == 1) ? wd[31:16] : wd[15:0];
        j.idx  = 16'(k);
        j.last = (r == n - 1) && (k == hi - 1);
        exp_q.push_back(j);
      end
      lo = hi;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic set_basic();
    fill_rand();
    mem[0]     = {16'($urandom), 16'd0};
    mem[1]     = {16'($urandom), 16'd2};
    mem[2]     = {16'($urandom), 16'd3};
    mem[8'h40] = 32'h0005_0001;
    mem[8'h41] = 32'h0000_0003;
  endtask

  task automatic gen_random(output int n);
    int acc, v;
    fill_rand();
    n   = $urandom_range(1, 10);
    acc = $urandom_range(0, 3);
    mem[0] = {16'($urandom), 16'(acc)};
    for (int r = 0; r < n; r++) begin
      if ($urandom_range(0, 15) == 0) begin
        v = (acc > 0 && $urandom_range(0, 1) == 1) ? acc - 1 : 300 + $urandom_range(0, 100);
      end else begin
        acc += $urandom_range(0, 4);
        v = acc;
      end
      mem[r + 1] = {16'($urandom), 16'(v)};
    end
  endtask

  task automatic begin_walk(input int n);
    obs_q.delete();
    reads    = 0;
    rd40     = 0;
    done_cnt = 0;
    busy_cnt = 0;
    cfg_num_block_rows = 16'(n);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("err_on_start", 64'(err), (n > 63) ? 64'd1 : 64'd0);
  endtask

  task automatic finish_walk(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 4000) begin
      cycle();
      t++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (2) cycle();
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_err_code"}, 64'(err_code), 64'(exp_code));
    check({tag, "_reads"}, 64'(reads), 64'(exp_reads));
    check({tag, "_njobs"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_job"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int n, t;
    rst_n = 1'b0; start = 1'b0; cfg_num_block_rows = 16'd0; job_ready = 1'b1;
    meta_rvalid = 1'b0; meta_rdata = 32'd0; lat = 2; pend = 1'b0; cnt = 0;
    paddr = 8'd0; ready_rand = 1'b0; hold_chk = 1'b0; addr_chk = 1'b1;
    reads = 0; rd40 = 0; done_cnt = 0; busy_cnt = 0;
    fill_rand();
    repeat (3) cycle();
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    cycle();

    set_basic(); ref_walk(2); begin_walk(2); finish_walk("basic");
    check("basic_rd40_once", 64'(rd40), 64'd1);

    fill_rand();
    mem[0] = 32'd0; mem[1] = 32'd0; mem[2] = 32'd1; mem[8'h40] = 32'h0000_0007;
    ref_walk(2); begin_walk(2); finish_walk("empty_row");

    set_basic(); ref_walk(2);
    job_ready = 1'b0;
    begin_walk(2);
    t = 0;
    while (!job_valid && t < 200) begin
      cycle();
      t++;
    end
    check("bp_first_valid", 64'(job_valid), 64'd1);
    repeat (5) cycle();
    job_ready = 1'b1;
    finish_walk("backpressure");

    fill_rand();
    mem[0] = 32'd3; mem[1] = 32'd1;
    ref_walk(1); begin_walk(1); finish_walk("err_nonmono");

    ref_walk(64); begin_walk(64); finish_walk("err_rows");

    set_basic(); ref_walk(2); begin_walk(2); finish_walk("err_cleared");

    ref_walk(0); begin_walk(0); finish_walk("n_zero");
    check("n_zero_busy_cycles", 64'(busy_cnt), 64'd1);

    set_basic(); ref_walk(2); begin_walk(2);
    t = 0;
    while (!(pend && paddr == 8'h40) && t < 200) begin
      cycle();
      t++;
    end
    check("mid_reset_reached_col", 64'(pend && paddr == 8'h40), 64'd1);
    rst_n = 1'b0;
    addr_chk = 1'b0;
    cycle();
    check("mid_reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    repeat (5) cycle();
    addr_chk = 1'b1;
    begin_walk(2); finish_walk("after_reset");

    for (int i = 0; i < 25; i++) begin
      gen_random(n);
      lat = $urandom_range(1, 3);
      ready_rand = 1'b1;
      ref_walk(n);
      begin_walk(n);
      if (i % 3 == 0) begin
        repeat (3) cycle();
        if (busy) begin
          cfg_num_block_rows = 16'($urandom);
          start = 1'b1;
          cycle();
          start = 1'b0;
        end
      end
      finish_walk("random");
    end
    ready_rand = 1'b0;
    job_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
